// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write bypass and busy scoreboard
module regfile_mp_sb #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREAD*RWIDTH-1:0]  ra,
  output logic [NREAD*DWIDTH-1:0]  rd,
  output logic [NREAD-1:0]         rbusy,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*RWIDTH-1:0] wa,
  input  logic [NWRITE*DWIDTH-1:0] wd,
  input  logic                     rsv_en,
  input  logic [RWIDTH-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [RWIDTH:0]          busy_cnt
);

  localparam int DEPTH = 2 ** RWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  clr;
  logic [DEPTH-1:0]  busy_next;
  logic [RWIDTH:0]   cnt_next;
  logic              rsv_hit;
  logic              accept;

  // Ascending port scan lets the highest-index write port win the bypass.
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd[i*DWIDTH +: DWIDTH] = mem[ra[i*RWIDTH +: RWIDTH]];
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j*RWIDTH +: RWIDTH] == ra[i*RWIDTH +: RWIDTH]))
          rd[i*DWIDTH +: DWIDTH] = wd[j*DWIDTH +: DWIDTH];
      end
      if (ra[i*RWIDTH +: RWIDTH] == '0)
        rd[i*DWIDTH +: DWIDTH] = '0;
      rbusy[i] = busy[ra[i*RWIDTH +: RWIDTH]];
    end
  end

  always_comb begin
    clr     = '0;
    rsv_hit = 1'b0;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j]) begin
        clr[wa[j*RWIDTH +: RWIDTH]] = 1'b1;
        if (wa[j*RWIDTH +: RWIDTH] == rsv_addr)
          rsv_hit = 1'b1;
      end
    end
    clr[0] = 1'b0;
  end

  assign rsv_ok = (rsv_addr == '0) || !busy[rsv_addr] || rsv_hit;
  assign accept = rsv_en && rsv_ok && (rsv_addr != '0);

  // Set after clear: a new reservation owns the register over a retiring writer.
  always_comb begin
    busy_next = busy & ~clr;
    if (accept)
      busy_next[rsv_addr] = 1'b1;
    busy_next[0] = 1'b0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_next = cnt_next + (RWIDTH+1)'(busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && (wa[j*RWIDTH +: RWIDTH] != '0))
          mem[wa[j*RWIDTH +: RWIDTH]] <= wd[j*DWIDTH +: DWIDTH];
      end
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;
  localparam int RW = 6;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int DEPTH = 2 ** RW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*RW-1:0]  ra;
  logic [NR*DW-1:0]  rd;
  logic [NR-1:0]     rbusy;
  logic [NW-1:0]     we;
  logic [NW*RW-1:0]  wa;
  logic [NW*DW-1:0]  wd;
  logic              rsv_en;
  logic [RW-1:0]     rsv_addr;
  logic              rsv_ok;
  logic [RW:0]       busy_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m [DEPTH];

  regfile_mp_sb #(.RWIDTH(RW), .DWIDTH(DW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int i);
    logic [RW-1:0] a;
    logic [DW-1:0] r;
    a = ra[i*RW +: RW];
    if (a == 0) return '0;
    r = mem_m[a];
    for (int j = 0; j < NW; j++)
      if (we[j] && wa[j*RW +: RW] == a) r = wd[j*DW +: DW];
    return r;
  endfunction

  function automatic bit model_rsv_ok();
    bit hit = 0;
    for (int j = 0; j < NW; j++)
      if (we[j] && wa[j*RW +: RW] == rsv_addr) hit = 1;
    return (rsv_addr == 0) || !busy_m[rsv_addr] || hit;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int a = 0; a < DEPTH; a++) c += int'(busy_m[a]);
    return c;
  endfunction

  task automatic idle();
    rst = 0; ra = '0; we = '0; wa = '0; wd = '0; rsv_en = 0; rsv_addr = '0;
  endtask

  task automatic set_w(input int j, input int a, input logic [DW-1:0] d);
    we[j] = 1'b1; wa[j*RW +: RW] = RW'(a); wd[j*DW +: DW] = d;
  endtask

  task automatic set_r(input int i, input int a);
    ra[i*RW +: RW] = RW'(a);
  endtask

  // Mid-cycle: compare combinational and registered outputs with the model.
  task automatic settle();
    @(negedge clk);
    check("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        check($sformatf("rd%0d", i), 64'(rd[i*DW +: DW]), 64'(model_rd(i)));
        check($sformatf("rbusy%0d", i), 64'(rbusy[i]), 64'(busy_m[ra[i*RW +: RW]]));
      end
      check("rsv_ok", 64'(rsv_ok), 64'(model_rsv_ok()));
    end
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = rsv_en && model_rsv_ok() && rsv_addr != 0;
    if (rst) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_m[a] = '0;
        busy_m[a] = 0;
      end
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (we[j] && wa[j*RW +: RW] != 0) begin
          mem_m[wa[j*RW +: RW]] = wd[j*DW +: DW];
          busy_m[wa[j*RW +: RW]] = 0;
        end
      end
      if (acc) busy_m[rsv_addr] = 1;
    end
    #1;
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  initial begin
    idle();
    rst = 1; tick(); idle();
    // reset wipes earlier write
    set_w(0, 5, 32'hDEADBEEF); cycle();
    idle(); rst = 1; cycle();
    idle(); set_r(0, 5); settle();
    check("t1_rd_r5", 64'(rd[DW-1:0]), 64'h0);
    check("t1_rbusy", 64'(rbusy), 64'h0);
    check("t1_cnt", 64'(busy_cnt), 64'h0);
    tick();
    // write with bypass
    idle(); set_w(0, 7, 32'h12345678); set_r(0, 7); settle();
    check("t2_bypass", 64'(rd[DW-1:0]), 64'h12345678);
    tick();
    idle(); set_r(0, 7); settle();
    check("t2_stored", 64'(rd[DW-1:0]), 64'h12345678);
    tick();
    // priority and r0
    idle(); set_w(0, 9, 32'hAAAA0000); set_w(1, 9, 32'h5555FFFF); set_r(1, 9); settle();
    check("t3_bypass_prio", 64'(rd[DW +: DW]), 64'h5555FFFF);
    tick();
    idle(); set_r(0, 9); settle();
    check("t3_prio", 64'(rd[DW-1:0]), 64'h5555FFFF);
    tick();
    idle(); set_w(0, 0, 32'hFFFFFFFF); settle();
    check("t3_r0_bypass", 64'(rd), 64'h0);
    tick();
    idle(); settle();
    check("t3_r0", 64'(rd), 64'h0);
    tick();
    // scoreboard
    idle(); rsv_en = 1; rsv_addr = 3; settle();
    check("t4_ok_first", 64'(rsv_ok), 64'h1);
    tick();
    idle(); set_r(0, 3); rsv_en = 1; rsv_addr = 3; settle();
    check("t4_rbusy", 64'(rbusy[0]), 64'h1);
    check("t4_cnt1", 64'(busy_cnt), 64'h1);
    check("t4_ok_second", 64'(rsv_ok), 64'h0);
    tick();
    idle(); set_w(0, 3, 32'h1); settle();
    check("t4_cnt_hold", 64'(busy_cnt), 64'h1);
    tick();
    idle(); set_r(0, 3); settle();
    check("t4_cnt_clr", 64'(busy_cnt), 64'h0);
    check("t4_rbusy_clr", 64'(rbusy[0]), 64'h0);
    tick();
    // simultaneous clear and set
    idle(); rsv_en = 1; rsv_addr = 4; cycle();
    idle(); set_w(0, 4, 32'h44); rsv_en = 1; rsv_addr = 4; settle();
    check("t5_ok", 64'(rsv_ok), 64'h1);
    tick();
    idle(); set_r(0, 4); settle();
    check("t5_busy", 64'(rbusy[0]), 64'h1);
    check("t5_cnt", 64'(busy_cnt), 64'h1);
    check("t5_mem", 64'(rd[DW-1:0]), 64'h44);
    tick();
    idle(); rsv_en = 1; rsv_addr = 6; cycle();
    idle(); set_w(0, 6, 32'h60); set_w(1, 6, 32'h61); cycle();
    idle(); settle();
    check("t5_dual_clr", 64'(busy_cnt), 64'h1);
    tick();
    // reset mid-operation
    idle(); set_w(0, 4, 32'h0); cycle();
    idle(); rsv_en = 1; rsv_addr = 1; cycle();
    rsv_addr = 2; cycle();
    rsv_addr = 10; cycle();
    idle(); settle();
    check("t6_cnt3", 64'(busy_cnt), 64'h3);
    tick();
    idle(); rst = 1; set_w(0, 2, 32'h22); cycle();
    idle(); set_r(0, 2); set_r(1, 1); set_r(2, 10); settle();
    check("t6_cnt0", 64'(busy_cnt), 64'h0);
    check("t6_rbusy", 64'(rbusy), 64'h0);
    check("t6_mem2", 64'(rd[DW-1:0]), 64'h0);
    tick();
    // randomized traffic over a small address window to force collisions
    for (int n = 0; n < 600; n++) begin
      idle();
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < NR; i++) set_r(i, $urandom_range(0, 7));
      for (int j = 0; j < NW; j++)
        if ($urandom_range(0, 2) == 0) set_w(j, $urandom_range(0, 7), $urandom);
      rsv_en = ($urandom_range(0, 1) == 1);
      rsv_addr = RW'($urandom_range(0, 7));
      cycle();
    end
    idle(); settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
